// File: rtl/mtx_row_accum.sv
// Row-reduce a 4x4 product matrix and accumulate saturating row totals over a
// group closed by i_last; the group result is offered on a valid/ready output.
module mtx_row_accum #(
  parameter int W     = 8,
  parameter int ACC_W = 24
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [16*2*W-1:0]     i_mtx_m,
  input  logic                  i_last,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [4*ACC_W-1:0]    o_row_sum,
  output logic [3:0]            o_ovf,
  output logic [7:0]            o_cnt
);
  localparam int P   = 2 * W;
  localparam int S   = P + 2;
  localparam int AW1 = ACC_W + 1;

  logic               stall;
  logic               accept;
  logic               s2_fire;
  logic               load;

  logic [S-1:0]       row_sum   [4];
  logic [S-1:0]       s1_sum_q  [4];
  logic               s1_valid_q;
  logic               s1_last_q;

  logic [ACC_W-1:0]   acc_q     [4];
  logic [ACC_W-1:0]   acc_d     [4];
  logic [AW1-1:0]     wide      [4];
  logic [3:0]         ovf_q, ovf_d;
  logic [7:0]         cnt_q, cnt_d;

  logic               o_valid_q;
  logic [4*ACC_W-1:0] row_sum_q;
  logic [3:0]         ovf_out_q;
  logic [7:0]         cnt_out_q;

  assign stall   = o_valid_q && !i_ready;
  assign o_ready = !stall;
  assign accept  = i_valid && o_ready;
  assign s2_fire = s1_valid_q && !stall;
  assign load    = s2_fire && s1_last_q;

  assign o_valid   = o_valid_q;
  assign o_row_sum = row_sum_q;
  assign o_ovf     = ovf_out_q;
  assign o_cnt     = cnt_out_q;

  // Two guard bits make the four-product sum lossless.
  always_comb begin
    for (int unsigned r = 0; r < 4; r++) begin
      row_sum[r] = '0;
      for (int unsigned c = 0; c < 4; c++) begin
        row_sum[r] = row_sum[r] + S'(i_mtx_m[P*(4*r+c) +: P]);
      end
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    for (int unsigned r = 0; r < 4; r++) begin
      wide[r] = {1'b0, acc_q[r]} + AW1'(s1_sum_q[r]);
      if (wide[r][ACC_W]) begin
        acc_d[r] = '1;
        ovf_d[r] = 1'b1;
      end else begin
        acc_d[r] = wide[r][ACC_W-1:0];
      end
    end
    cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      for (int unsigned r = 0; r < 4; r++) begin
        s1_sum_q[r] <= '0;
        acc_q[r]    <= '0;
      end
      ovf_q     <= '0;
      cnt_q     <= '0;
      o_valid_q <= 1'b0;
      row_sum_q <= '0;
      ovf_out_q <= '0;
      cnt_out_q <= '0;
    end else begin
      if (!stall) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_sum_q  <= row_sum;
          s1_last_q <= i_last;
        end
      end

      // A closing beat publishes the updated totals and restarts the group.
      if (s2_fire) begin
        if (s1_last_q) begin
          for (int unsigned r = 0; r < 4; r++) begin
            row_sum_q[ACC_W*r +: ACC_W] <= acc_d[r];
            acc_q[r]                    <= '0;
          end
          ovf_out_q <= ovf_d;
          cnt_out_q <= cnt_d;
          ovf_q     <= '0;
          cnt_q     <= '0;
        end else begin
          acc_q <= acc_d;
          ovf_q <= ovf_d;
          cnt_q <= cnt_d;
        end
      end

      if (load) begin
        o_valid_q <= 1'b1;
      end else if (o_valid_q && i_ready) begin
        o_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mtx_row_accum.md
# mtx_row_accum

Downstream consumer of the elementwise multiplier. It takes the 4x4 matrix of 16-bit products, reduces each row to a single sum, and accumulates those row sums over a group of beats that ends with `i_last`. When a group completes it presents the four saturating row totals, an overflow flag per row and a beat count on a valid/ready output. It is the reduction half of the multiply-accumulate datapath; the controller reads its results.

## Interface
- `W`, default 8: input operand element width. Product element width is `P = 2*W`.
- `ACC_W`, default 24: per-row accumulator width. Must satisfy `ACC_W >= 2*W+2`.
- `clk`, input, 1: single clock, rising edge.
- `rstn`, input, 1: reset, asynchronous and active-low.
- `i_valid`, input, 1: `i_mtx_m` and `i_last` are valid.
- `o_ready`, output, 1: block accepts a beat this cycle.
- `i_mtx_m`, input, 16*P: 4x4 product matrix, unsigned.
  - Element k sits at bits `[P*k+P-1 : P*k]`.
  - Row r is elements 4r..4r+3 (row-major, element 0 at the LSBs).
- `i_last`, input, 1: this beat closes the current accumulation group.
- `o_valid`, output, 1: result registers hold an unconsumed group result.
- `i_ready`, input, 1: downstream takes the result.
- `o_row_sum`, output, 4*ACC_W: row r total at bits `[ACC_W*r+ACC_W-1 : ACC_W*r]`.
- `o_ovf`, output, 4: bit r is set if row r saturated anywhere in the group.
- `o_cnt`, output, 8: beats in the group, saturating at 255.

## Operation
- **Accept and stall:** a beat is accepted on a rising edge when `i_valid && o_ready`.
  - `o_ready = !(o_valid && !i_ready)` (combinational).
  - `stall = o_valid && !i_ready` freezes every pipeline register.
- **Stage S1 (row reduce):** on an accepted beat, register the four row sums of 4 products (P+2 bits each, unsigned, no loss), plus `s1_valid` and `s1_last`.
  - If the pipeline is not stalled and no beat is accepted, `s1_valid` clears.
- **Stage S2 (accumulate):** when `s1_valid && !stall`:
  - `acc[r] = sat(acc[r] + s1_sum[r])`, where `sat` clamps to `2^ACC_W-1`.
  - `ovf[r]` is sticky-ORed with a saturation event.
  - `cnt` increments, saturating at 255.
- **Group close:** if `s1_last` is also set, the updated values go to `o_row_sum`, `o_ovf` and `o_cnt`, and `o_valid` is set.
  - In the same edge `acc`, `ovf` and `cnt` clear to 0, so the next beat starts a fresh group.
- **Output handshake:** `o_valid` clears on an edge with `o_valid && i_ready`, unless a new result loads on that same edge, in which case it stays 1 with the new data.
- **Output hold:** output registers change only when a result loads.
- **States:**
  - IDLE: `s1_valid=0`, `cnt=0`.
  - ACCUM: partial group held.
  - HOLD: `o_valid=1`.
  - ACCUM and HOLD may coexist. The next group can fill S1 and S2 while a result is held, until the pipeline stalls.

## Timing
- **Reset values:** `o_valid=0`, `o_row_sum=0`, `o_ovf=0`, `o_cnt=0`, `o_ready=1`. Internal `acc`, `ovf`, `cnt`, `s1_valid` and `s1_last` are also 0.
- **Latency:** a last beat accepted at edge T gives `o_valid=1` after edge T+1, provided edge T+1 is not stalled.
- **Throughput:** one beat per cycle when `i_ready` is high.
- **Single-beat group:** `i_last` on the first beat produces that beat's row sums with `o_cnt=1`.
- **Back-to-back groups:** a last beat followed immediately by a new beat gives no gap. The new group accumulates from 0.
- **Simultaneous consume and load:** `o_valid && i_ready` on the edge where a new result loads keeps `o_valid=1` and shows the new data. No result is lost or duplicated.
- **Backpressure:** while `o_valid && !i_ready`:
  - `o_ready=0` and no beat is accepted.
  - S1, `acc` and the outputs hold unchanged.
  - `i_mtx_m` is ignored.
- **Reset mid-operation:** `rstn` low asynchronously clears all state. The partial group and any held result are discarded.
- **Saturation:** a saturated row stays at `2^ACC_W-1` for the rest of the group. Other rows are unaffected.

## Test plan
- **Reset:** hold `rstn` low 4 cycles -> all outputs 0, `o_ready=1`. Assert reset mid-group -> outputs return to 0 at once and the next group starts clean.
- **Single beat:** every row is products [1,4,9,16], `i_last=1`, `i_ready=1` -> two cycles later `o_valid=1`, each row sum = 30, `o_cnt=1`, `o_ovf=0`. One cycle after that, `o_valid=0`.
- **Three-beat group:** the same matrix for 3 consecutive beats, last on the third -> row sums 90, `o_cnt=3`. Immediately follow with a single last beat of all-ones products -> next result row sums 4, `o_cnt=1`, with no idle cycle between results.
- **Backpressure:** with a result pending and `i_ready=0` for 3 cycles while `i_valid=1` -> `o_ready=0`, `o_row_sum` stable, no beat counted. When `i_ready` returns to 1, the stalled beats accept in order and the totals match the reference model.
- **Saturation:** 70 beats of all products 0xFE01, last on the 70th -> each row sum = 16777215, `o_ovf=4'hF`, `o_cnt=70`. Next group with products [1,4,9,16] -> 30, `o_ovf=0`.
- **Random:** random products, random `i_last` and random `i_valid`/`i_ready` over 10k cycles against a scoreboard -> every group total, flag and count matches.
